// File: rtl/decode_stage.sv
// decode_stage: receiving end of the fetch->decode bundle interface.
// Buffers two-instruction bundles in a DEPTH-entry FIFO, decodes both RV32I
// slots at the FIFO head and presents a registered decode->rename bundle.
//   clk, reset (async, active-high), flush (sync, drops everything)
//   fd_valid/fd_ready, inst_a/inst_b, pc_a/pc_b     : fetch side
//   dr_valid/dr_ready, dr_pc_*, dr_rd_*, dr_rs1_*,
//   dr_rs2_*, dr_imm_*, dr_funct_*, dr_ctrl_*       : rename side
// Optional macro DECODE_ILLEGAL_TRAP_EN adds dr_illegal_a/dr_illegal_b and a
// sticky illegal_seen flag (cleared only by reset).
module decode_stage #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            fd_valid,
    output logic            fd_ready,
    input  logic [XLEN-1:0] inst_a,
    input  logic [XLEN-1:0] inst_b,
    input  logic [XLEN-1:0] pc_a,
    input  logic [XLEN-1:0] pc_b,
    output logic            dr_valid,
    input  logic            dr_ready,
    output logic [XLEN-1:0] dr_pc_a,
    output logic [XLEN-1:0] dr_pc_b,
    output logic [4:0]      dr_rd_a,
    output logic [4:0]      dr_rd_b,
    output logic [4:0]      dr_rs1_a,
    output logic [4:0]      dr_rs1_b,
    output logic [4:0]      dr_rs2_a,
    output logic [4:0]      dr_rs2_b,
    output logic [XLEN-1:0] dr_imm_a,
    output logic [XLEN-1:0] dr_imm_b,
    output logic [9:0]      dr_funct_a,
    output logic [9:0]      dr_funct_b,
    output logic [7:0]      dr_ctrl_a,
    output logic [7:0]      dr_ctrl_b
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic            dr_illegal_a,
    output logic            dr_illegal_b,
    output logic            illegal_seen
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = 4 * XLEN;

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [9:0]      funct;
        logic [7:0]      ctrl;
    } dec_t;

    // ctrl: [7] slot_valid [6] upper_imm [5] jump [4] branch
    //       [3] mem_write [2] mem_read [1] alu_src_imm [0] reg_write
    function automatic dec_t decode(input logic [31:0] i);
        dec_t        d;
        logic [31:0] imm;
        d       = '0;
        imm     = '0;
        d.rd    = i[11:7];
        d.rs1   = i[19:15];
        d.rs2   = i[24:20];
        d.funct = {i[31:25], i[14:12]};
        case (i[6:0])
            7'b0110011: d.ctrl = 8'h81;
            7'b0010011: begin d.ctrl = 8'h83; imm = {{20{i[31]}}, i[31:20]}; end
            7'b0000011: begin d.ctrl = 8'h87; imm = {{20{i[31]}}, i[31:20]}; end
            7'b0100011: begin
                d.ctrl = 8'h8A; d.rd = '0;
                imm = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            7'b1100011: begin
                d.ctrl = 8'h90; d.rd = '0;
                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            7'b1101111: begin
                d.ctrl = 8'hA1;
                imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            7'b1100111: begin d.ctrl = 8'hA3; imm = {{20{i[31]}}, i[31:20]}; end
            7'b0110111,
            7'b0010111: begin d.ctrl = 8'hC1; imm = {i[31:12], 12'b0}; end
            // empty slot (all zero) lands here too
            default:    begin d.ctrl = '0; d.rd = '0; end
        endcase
        d.imm = XLEN'($signed(imm));
        return d;
    endfunction

    logic [BW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    dec_t          r_out_a, r_out_b;
    logic [XLEN-1:0] r_pc_a, r_pc_b;

    logic [BW-1:0] w_head;
    logic          w_push, w_pop;
    dec_t          w_dec_a, w_dec_b;

    // head layout: {inst_a, inst_b, pc_a, pc_b}
    assign w_head  = r_mem[r_rp];
    assign w_dec_a = decode(w_head[4*XLEN-1 -: 32]);
    assign w_dec_b = decode(w_head[3*XLEN-1 -: 32]);

    // ready is count-based only: a full FIFO refuses even when popping
    assign fd_ready = (r_cnt < CW'(DEPTH));
    assign w_push   = fd_valid && fd_ready && !flush;
    assign w_pop    = (r_cnt != '0) && (!r_valid || dr_ready) && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // storage needs no reset: count/pointers define what is live
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {inst_a, inst_b, pc_a, pc_b};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_out_a <= '0;
            r_out_b <= '0;
            r_pc_a  <= '0;
            r_pc_b  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_pop) begin
            r_valid <= 1'b1;
            r_out_a <= w_dec_a;
            r_out_b <= w_dec_b;
            r_pc_a  <= w_head[2*XLEN-1 -: XLEN];
            r_pc_b  <= w_head[XLEN-1:0];
        end else if (dr_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign dr_valid   = r_valid;
    assign dr_pc_a    = r_pc_a;
    assign dr_pc_b    = r_pc_b;
    assign dr_rd_a    = r_out_a.rd;
    assign dr_rd_b    = r_out_b.rd;
    assign dr_rs1_a   = r_out_a.rs1;
    assign dr_rs1_b   = r_out_b.rs1;
    assign dr_rs2_a   = r_out_a.rs2;
    assign dr_rs2_b   = r_out_b.rs2;
    assign dr_imm_a   = r_out_a.imm;
    assign dr_imm_b   = r_out_b.imm;
    assign dr_funct_a = r_out_a.funct;
    assign dr_funct_b = r_out_b.funct;
    assign dr_ctrl_a  = r_out_a.ctrl;
    assign dr_ctrl_b  = r_out_b.ctrl;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic w_ill_a, w_ill_b;
    logic r_ill_a, r_ill_b, r_ill_seen;

    // nonzero word that did not decode to a valid slot
    assign w_ill_a = (|w_head[4*XLEN-1 -: XLEN]) && !w_dec_a.ctrl[7];
    assign w_ill_b = (|w_head[3*XLEN-1 -: XLEN]) && !w_dec_b.ctrl[7];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ill_a    <= 1'b0;
            r_ill_b    <= 1'b0;
            r_ill_seen <= 1'b0;
        end else if (w_pop) begin
            r_ill_a <= w_ill_a;
            r_ill_b <= w_ill_b;
            if (w_ill_a || w_ill_b) r_ill_seen <= 1'b1;
        end
    end

    assign dr_illegal_a = r_ill_a;
    assign dr_illegal_b = r_ill_b;
    assign illegal_seen = r_ill_seen;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; expected values are hand-computed.
module tb_decode_stage;
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic        fd_valid = 1'b0, dr_ready = 1'b1;
    logic        fd_ready, dr_valid;
    logic [31:0] inst_a = '0, inst_b = '0, pc_a = '0, pc_b = '0;
    logic [31:0] dr_pc_a, dr_pc_b, dr_imm_a, dr_imm_b;
    logic [4:0]  dr_rd_a, dr_rd_b, dr_rs1_a, dr_rs1_b, dr_rs2_a, dr_rs2_b;
    logic [9:0]  dr_funct_a, dr_funct_b;
    logic [7:0]  dr_ctrl_a, dr_ctrl_b;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        dr_illegal_a, dr_illegal_b, illegal_seen;
`endif

    int n_chk = 0, n_fail = 0;

    decode_stage #(.DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fd_valid(fd_valid), .fd_ready(fd_ready),
        .inst_a(inst_a), .inst_b(inst_b), .pc_a(pc_a), .pc_b(pc_b),
        .dr_valid(dr_valid), .dr_ready(dr_ready),
        .dr_pc_a(dr_pc_a), .dr_pc_b(dr_pc_b),
        .dr_rd_a(dr_rd_a), .dr_rd_b(dr_rd_b),
        .dr_rs1_a(dr_rs1_a), .dr_rs1_b(dr_rs1_b),
        .dr_rs2_a(dr_rs2_a), .dr_rs2_b(dr_rs2_b),
        .dr_imm_a(dr_imm_a), .dr_imm_b(dr_imm_b),
        .dr_funct_a(dr_funct_a), .dr_funct_b(dr_funct_b),
        .dr_ctrl_a(dr_ctrl_a), .dr_ctrl_b(dr_ctrl_b)
`ifdef DECODE_ILLEGAL_TRAP_EN
        , .dr_illegal_a(dr_illegal_a), .dr_illegal_b(dr_illegal_b),
        .illegal_seen(illegal_seen)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] pa, input logic [31:0] pb);
        fd_valid = 1'b1; inst_a = ia; inst_b = ib; pc_a = pa; pc_b = pb;
    endtask

    // push one bundle, then give it one more edge to reach dr_*
    task automatic send(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] pa, input logic [31:0] pb);
        drive(ia, ib, pa, pb);
        step();
        fd_valid = 1'b0;
        step();
    endtask

    initial begin
        #12;
        chk("rst_valid", {31'b0, dr_valid}, 32'd0);
        chk("rst_imm_a", dr_imm_a, 32'd0);
        chk("rst_ctrl_b", {24'b0, dr_ctrl_b}, 32'd0);
        reset = 1'b0;
        step();
        chk("rst_fd_ready", {31'b0, fd_ready}, 32'd1);

        // add x3,x1,x2 / addi x1,x0,-1
        send(32'h002081B3, 32'hFFF00093, 32'h0, 32'h4);
        chk("t1_valid", {31'b0, dr_valid}, 32'd1);
        chk("t1_rd_a", {27'b0, dr_rd_a}, 32'd3);
        chk("t1_rs1_a", {27'b0, dr_rs1_a}, 32'd1);
        chk("t1_rs2_a", {27'b0, dr_rs2_a}, 32'd2);
        chk("t1_ctrl_a", {24'b0, dr_ctrl_a}, 32'h81);
        chk("t1_rd_b", {27'b0, dr_rd_b}, 32'd1);
        chk("t1_imm_b", dr_imm_b, 32'hFFFFFFFF);
        chk("t1_ctrl_b", {24'b0, dr_ctrl_b}, 32'h83);
        chk("t1_rs2_b", {27'b0, dr_rs2_b}, 32'h1F);
        chk("t1_funct_b", {22'b0, dr_funct_b}, 32'h3F8);
        chk("t1_pc_b", dr_pc_b, 32'h4);

        // sw x2,8(x1) / empty
        send(32'h0020A423, 32'h0, 32'h8, 32'hC);
        chk("t2_ctrl_a", {24'b0, dr_ctrl_a}, 32'h8A);
        chk("t2_imm_a", dr_imm_a, 32'd8);
        chk("t2_rd_a", {27'b0, dr_rd_a}, 32'd0);
        chk("t2_funct_a", {22'b0, dr_funct_a}, 32'h2);
        chk("t2_ctrl_b", {24'b0, dr_ctrl_b}, 32'h00);
        chk("t2_rd_b", {27'b0, dr_rd_b}, 32'd0);

        // beq x1,x2,-4 / jal x1,8
        send(32'hFE208EE3, 32'h008000EF, 32'h10, 32'h14);
        chk("t3_ctrl_a", {24'b0, dr_ctrl_a}, 32'h90);
        chk("t3_imm_a", dr_imm_a, 32'hFFFFFFFC);
        chk("t3_rd_a", {27'b0, dr_rd_a}, 32'd0);
        chk("t3_ctrl_b", {24'b0, dr_ctrl_b}, 32'hA1);
        chk("t3_imm_b", dr_imm_b, 32'd8);
        chk("t3_rd_b", {27'b0, dr_rd_b}, 32'd1);

        // lui x5,0x12345 / lw x4,-8(x2)
        send(32'h123452B7, 32'hFF812203, 32'h18, 32'h1C);
        chk("t4_ctrl_a", {24'b0, dr_ctrl_a}, 32'hC1);
        chk("t4_imm_a", dr_imm_a, 32'h12345000);
        chk("t4_rd_a", {27'b0, dr_rd_a}, 32'd5);
        chk("t4_ctrl_b", {24'b0, dr_ctrl_b}, 32'h87);
        chk("t4_imm_b", dr_imm_b, 32'hFFFFFFF8);
        chk("t4_rs1_b", {27'b0, dr_rs1_b}, 32'd2);

        // jalr x0,0(x1) / unknown opcode
        send(32'h00008067, 32'h0000007F, 32'h20, 32'h24);
        chk("t5_ctrl_a", {24'b0, dr_ctrl_a}, 32'hA3);
        chk("t5_ctrl_b", {24'b0, dr_ctrl_b}, 32'h00);
        chk("t5_rd_b", {27'b0, dr_rd_b}, 32'd0);
        step();
        chk("t5_drain", {31'b0, dr_valid}, 32'd0);

        // stall: output holds P, FIFO fills with B1,B2, B3 waits
        dr_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'h100, 32'h104);
        drive(32'h002081B3, 32'h0, 32'h200, 32'h204);
        step();
        drive(32'h002081B3, 32'h0, 32'h300, 32'h304);
        step();
        chk("st_fd_ready", {31'b0, fd_ready}, 32'd0);
        drive(32'h002081B3, 32'h0, 32'h400, 32'h404);
        step();
        step();
        chk("st_hold_valid", {31'b0, dr_valid}, 32'd1);
        chk("st_hold_pc", dr_pc_a, 32'h100);
        chk("st_hold_ctrl", {24'b0, dr_ctrl_a}, 32'h81);
        dr_ready = 1'b1;
        step();
        chk("st_d1", dr_pc_a, 32'h200);
        step();
        fd_valid = 1'b0;
        chk("st_d2", dr_pc_a, 32'h300);
        step();
        chk("st_d3", dr_pc_a, 32'h400);
        chk("st_d3_valid", {31'b0, dr_valid}, 32'd1);
        step();
        chk("st_empty", {31'b0, dr_valid}, 32'd0);

        // flush with a full FIFO and a bundle offered
        dr_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'h500, 32'h504);
        drive(32'h002081B3, 32'h0, 32'h600, 32'h604);
        step();
        drive(32'h002081B3, 32'h0, 32'h700, 32'h704);
        step();
        chk("fl_full", {31'b0, fd_ready}, 32'd0);
        drive(32'h002081B3, 32'h0, 32'h800, 32'h804);
        flush = 1'b1;
        step();
        flush = 1'b0;
        fd_valid = 1'b0;
        chk("fl_valid", {31'b0, dr_valid}, 32'd0);
        chk("fl_fd_ready", {31'b0, fd_ready}, 32'd1);
        dr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fl_gone", {31'b0, dr_valid}, 32'd0);
        end

        // async reset mid-stall with count==2
        dr_ready = 1'b0;
        send(32'h002081B3, 32'hFFF00093, 32'h900, 32'h904);
        drive(32'h002081B3, 32'h0, 32'hA00, 32'hA04);
        step();
        drive(32'h002081B3, 32'h0, 32'hB00, 32'hB04);
        step();
        fd_valid = 1'b0;
        chk("ar_pre_valid", {31'b0, dr_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", {31'b0, dr_valid}, 32'd0);
        chk("ar_pc_a", dr_pc_a, 32'd0);
        chk("ar_ctrl_a", {24'b0, dr_ctrl_a}, 32'd0);
        chk("ar_imm_b", dr_imm_b, 32'd0);
        #10 reset = 1'b0;
        dr_ready = 1'b1;
        step();
        chk("ar_fd_ready", {31'b0, fd_ready}, 32'd1);
        chk("ar_no_stale", {31'b0, dr_valid}, 32'd0);
        send(32'hFE208EE3, 32'h123452B7, 32'hC00, 32'hC04);
        chk("ar_resume_pc", dr_pc_a, 32'hC00);
        chk("ar_resume_ctrl", {24'b0, dr_ctrl_a}, 32'h90);
        chk("ar_resume_imm_b", dr_imm_b, 32'h12345000);

`ifdef DECODE_ILLEGAL_TRAP_EN
        send(32'h0000007F, 32'h0, 32'hD00, 32'hD04);
        chk("il_a", {31'b0, dr_illegal_a}, 32'd1);
        chk("il_b_empty", {31'b0, dr_illegal_b}, 32'd0);
        chk("il_ctrl_a", {24'b0, dr_ctrl_a}, 32'd0);
        chk("il_seen", {31'b0, illegal_seen}, 32'd1);
        send(32'h002081B3, 32'h0, 32'hE00, 32'hE04);
        chk("il_clear_a", {31'b0, dr_illegal_a}, 32'd0);
        chk("il_sticky", {31'b0, illegal_seen}, 32'd1);
        reset = 1'b1;
        #1;
        chk("il_reset", {31'b0, illegal_seen}, 32'd0);
        #10 reset = 1'b0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end
endmodule
